lc3_decode_stage: RTL and testbench
===================================

# lc3_decode_stage

Synthesizable LC3 Decode pipeline stage: the receiving end of the decode_in interface. It captures `Instr_dout`/`npc_in` on cycles where `enable_decode` is high and produces registered instruction, next-PC and control words for the Execute, Writeback and Memory stages. It sits between Fetch/instruction memory and Execute and is the DUT driven by the decode_in agent.

## Interface
Parameters:
- none; widths are fixed by the LC3 ISA.

Ports:
- `clock` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-low reset.
- `enable_decode` input 1: capture qualifier from the controller.
- `Instr_dout` input 16: instruction word from instruction memory.
- `npc_in` input 16: PC+1 of that instruction from Fetch.
- `IR` output 16: registered instruction.
- `npc_out` output 16: registered `npc_in`.
- `E_Control` output 6: {alu_control[1:0], pcselect1[1:0], pcselect2, op2select}.
- `W_Control` output 2: writeback select; 00 ALU, 01 memory, 10 PC/LEA.
- `Mem_Control` output 1: 1 for indirect accesses (LDI/STI), else 0.
- `decode_valid` output 1: high the cycle after a capture.
- `illegal_op` output 1: present only with DECODE_ILLEGAL_TRAP_EN.

## Operation
- All outputs are registers. There is no combinational path from inputs to outputs.
- Reset (`reset`=0 at a rising edge): every output becomes 0, including `illegal_op`. Reset overrides `enable_decode`.
- Capture (`reset`=1, `enable_decode`=1):
  - `IR`<=`Instr_dout` and `npc_out`<=`npc_in`.
  - Control words are decoded from `Instr_dout[15:12]`.
  - `decode_valid`<=1.
- Hold (`reset`=1, `enable_decode`=0): `IR`, `npc_out` and the control outputs keep their values; `decode_valid`<=0.
- Decode, given as alu/pcsel1/pcsel2/op2, then W, then Mem:
  - ADD 0001: 00/00/0/~IR[5], W00, M0.
  - AND 0101: 01/00/0/~IR[5], W00, M0.
  - NOT 1001: 10/00/0/0, W00, M0.
  - BR 0000: 00/01/1/0, W00, M0.
  - JMP 1100: 00/11/0/0, W00, M0.
  - LD 0010: 00/01/1/0, W01, M0.
  - LDR 0110: 00/10/0/0, W01, M0.
  - LDI 1010: 00/01/1/0, W01, M1.
  - LEA 1110: 00/01/1/0, W10, M0.
  - ST 0011: 00/01/1/0, W00, M0.
  - STR 0111: 00/10/0/0, W00, M0.
  - STI 1011: 00/01/1/0, W00, M1.
  - All other opcodes: E_Control=0, W_Control=0, Mem_Control=0. `IR` and `npc_out` are still captured.
- No arithmetic is performed. `npc_out` is a pure copy; there is no wrap handling.

## Timing
- Latency: 1 cycle from the capturing edge to valid outputs.
- Throughput: one instruction per cycle while `enable_decode` stays high.
- Back-to-back captures: each edge fully replaces the previous outputs.
- Reset released mid-stream: the first edge with `reset`=1 and `enable_decode`=1 captures normally. With `enable_decode`=0 the outputs stay 0.
- Reset asserted at an edge where `enable_decode`=1: the outputs go to 0 and the instruction is dropped.
- Inputs must be stable at the rising edge. The decode_in driver updates inputs after the edge, so sampling occurs at the next edge.

## Configuration
- DECODE_ILLEGAL_TRAP_EN defined:
  - Adds the `illegal_op` output port.
  - On capture, `illegal_op`<=1 for opcodes 1000, 1101 or 1111, else 0.
  - `illegal_op` holds while `enable_decode`=0 and resets to 0.
  - Flagged opcodes also force E_Control, W_Control and Mem_Control to 0.
- DECODE_ILLEGAL_TRAP_EN undefined:
  - The `illegal_op` port does not exist.
  - Those opcodes decode as "all other opcodes" with no flag.

## Test plan
- Reset: hold `reset`=0 for 2 cycles with `enable_decode`=1 and `Instr_dout`=0x1283 -> all outputs 0, `decode_valid`=0.
- ADD register mode: `Instr_dout`=0x1283, `npc_in`=0x3001, enable=1 -> next cycle `IR`=0x1283, `npc_out`=0x3001, `E_Control`=6'b000001, `W_Control`=00, `Mem_Control`=0, `decode_valid`=1.
- Back-to-back capture:
  - 0x52A5 (AND immediate) -> `E_Control`=6'b010000.
  - Then 0xA405 (LDI) -> `E_Control`=6'b000110, `W_Control`=01, `Mem_Control`=1.
  - Then 0xE3FF (LEA) -> `E_Control`=6'b000110, `W_Control`=10, `Mem_Control`=0.
- Hold: after capturing 0x1283, drive enable=0 with `Instr_dout`=0x5FFF -> `IR` stays 0x1283, controls unchanged, `decode_valid`=0.
- Reset mid-stream: capture 0xA405, then at the next edge drive `reset`=0 with enable=1 and 0x1283 -> all outputs 0. Release reset with 0x1283 -> captured one cycle later.
- Illegal opcode (macro on): capture 0xD000 -> `illegal_op`=1, E/W/Mem=0. Capture 0x1283 -> `illegal_op`=0.

Source files
------------

// File: rtl/lc3_decode_stage_if.sv
// Decode-stage bus: capture inputs from Fetch/instruction memory and registered decode outputs.
// The illegal_op signal exists only when DECODE_ILLEGAL_TRAP_EN is defined.
interface lc3_decode_stage_if;
    logic        enable_decode;
    logic [15:0] Instr_dout;
    logic [15:0] npc_in;
    logic [15:0] IR;
    logic [15:0] npc_out;
    logic [5:0]  E_Control;
    logic [1:0]  W_Control;
    logic        Mem_Control;
    logic        decode_valid;
`ifdef DECODE_ILLEGAL_TRAP_EN
    logic        illegal_op;
`endif

    modport master (
        output enable_decode, Instr_dout, npc_in,
        input  IR, npc_out, E_Control, W_Control, Mem_Control, decode_valid
`ifdef DECODE_ILLEGAL_TRAP_EN
        , input illegal_op
`endif
    );

    modport slave (
        input  enable_decode, Instr_dout, npc_in,
        output IR, npc_out, E_Control, W_Control, Mem_Control, decode_valid
`ifdef DECODE_ILLEGAL_TRAP_EN
        , output illegal_op
`endif
    );
endinterface

// File: rtl/lc3_decode_stage.sv
// LC3 decode pipeline stage: registers the instruction/next-PC and decodes E/W/Mem control words.
// Optional DECODE_ILLEGAL_TRAP_EN adds illegal_op for opcodes 1000, 1101 and 1111.
module lc3_decode_stage (
    input logic               clock,
    input logic               reset,
    lc3_decode_stage_if.slave dec
);
    localparam int unsigned INSTR_W = 16;
    localparam int unsigned ECTL_W  = 6;
    localparam int unsigned WCTL_W  = 2;

    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_LD  = 4'b0010;
    localparam logic [3:0] OP_ST  = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_NOT = 4'b1001;
    localparam logic [3:0] OP_LDI = 4'b1010;
    localparam logic [3:0] OP_STI = 4'b1011;
    localparam logic [3:0] OP_JMP = 4'b1100;
    localparam logic [3:0] OP_LEA = 4'b1110;

    localparam logic [1:0] W_ALU = 2'b00;
    localparam logic [1:0] W_MEM = 2'b01;
    localparam logic [1:0] W_PC  = 2'b10;

    logic [INSTR_W-1:0] ir_q, npc_q;
    logic [ECTL_W-1:0]  e_ctl_q, e_ctl_d;
    logic [WCTL_W-1:0]  w_ctl_q, w_ctl_d;
    logic               mem_ctl_q, mem_ctl_d;
    logic               valid_q;
    logic [3:0]         opcode;
    logic               imm_n;

    assign opcode = dec.Instr_dout[15:12];
    assign imm_n  = ~dec.Instr_dout[5];

`ifdef DECODE_ILLEGAL_TRAP_EN
    logic ill_q, ill_d;
`endif

    // E_Control = {alu_control, pcselect1, pcselect2, op2select}
    always_comb begin
        e_ctl_d   = '0;
        w_ctl_d   = W_ALU;
        mem_ctl_d = 1'b0;
        case (opcode)
            OP_ADD: e_ctl_d = {2'b00, 2'b00, 1'b0, imm_n};
            OP_AND: e_ctl_d = {2'b01, 2'b00, 1'b0, imm_n};
            OP_NOT: e_ctl_d = {2'b10, 2'b00, 1'b0, 1'b0};
            OP_BR:  e_ctl_d = {2'b00, 2'b01, 1'b1, 1'b0};
            OP_JMP: e_ctl_d = {2'b00, 2'b11, 1'b0, 1'b0};
            OP_LD: begin
                e_ctl_d = {2'b00, 2'b01, 1'b1, 1'b0};
                w_ctl_d = W_MEM;
            end
            OP_LDR: begin
                e_ctl_d = {2'b00, 2'b10, 1'b0, 1'b0};
                w_ctl_d = W_MEM;
            end
            OP_LDI: begin
                e_ctl_d   = {2'b00, 2'b01, 1'b1, 1'b0};
                w_ctl_d   = W_MEM;
                mem_ctl_d = 1'b1;
            end
            OP_LEA: begin
                e_ctl_d = {2'b00, 2'b01, 1'b1, 1'b0};
                w_ctl_d = W_PC;
            end
            OP_ST:  e_ctl_d = {2'b00, 2'b01, 1'b1, 1'b0};
            OP_STR: e_ctl_d = {2'b00, 2'b10, 1'b0, 1'b0};
            OP_STI: begin
                e_ctl_d   = {2'b00, 2'b01, 1'b1, 1'b0};
                mem_ctl_d = 1'b1;
            end
            default: ;
        endcase
`ifdef DECODE_ILLEGAL_TRAP_EN
        ill_d = (opcode == 4'b1000) || (opcode == 4'b1101) || (opcode == 4'b1111);
        if (ill_d) begin
            e_ctl_d   = '0;
            w_ctl_d   = W_ALU;
            mem_ctl_d = 1'b0;
        end
`endif
    end

    // Capture on enable; hold otherwise with decode_valid dropping; reset wins over enable.
    always_ff @(posedge clock) begin
        if (!reset) begin
            ir_q      <= '0;
            npc_q     <= '0;
            e_ctl_q   <= '0;
            w_ctl_q   <= '0;
            mem_ctl_q <= 1'b0;
            valid_q   <= 1'b0;
`ifdef DECODE_ILLEGAL_TRAP_EN
            ill_q     <= 1'b0;
`endif
        end else if (dec.enable_decode) begin
            ir_q      <= dec.Instr_dout;
            npc_q     <= dec.npc_in;
            e_ctl_q   <= e_ctl_d;
            w_ctl_q   <= w_ctl_d;
            mem_ctl_q <= mem_ctl_d;
            valid_q   <= 1'b1;
`ifdef DECODE_ILLEGAL_TRAP_EN
            ill_q     <= ill_d;
`endif
        end else begin
            valid_q   <= 1'b0;
        end
    end

    assign dec.IR           = ir_q;
    assign dec.npc_out      = npc_q;
    assign dec.E_Control    = e_ctl_q;
    assign dec.W_Control    = w_ctl_q;
    assign dec.Mem_Control  = mem_ctl_q;
    assign dec.decode_valid = valid_q;
`ifdef DECODE_ILLEGAL_TRAP_EN
    assign dec.illegal_op   = ill_q;
`endif
endmodule

// File: tb/tb_lc3_decode_stage.sv
// Scoreboard bench for lc3_decode_stage: directed plan vectors followed by random traffic.
module tb_lc3_decode_stage;
    typedef struct packed {
        logic [15:0] ir;
        logic [15:0] npc;
        logic [5:0]  e;
        logic [1:0]  w;
        logic        m;
        logic        v;
        logic        ill;
    } exp_t;

    logic clock;
    logic reset;
    lc3_decode_stage_if dec_if();

    lc3_decode_stage dut (
        .clock (clock),
        .reset (reset),
        .dec   (dec_if.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    exp_t sb[$];
    exp_t model;
    int   total  = 0;
    int   passed = 0;

    // Per-opcode decode table in the ISA's own field terms.
    int alu_t[16], p1_t[16], p2_t[16], op2imm_t[16], w_t[16], m_t[16], ill_t[16];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        total++;
        if (act !== req)
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        else
            passed++;
    endtask

    task automatic fill_tables();
        for (int i = 0; i < 16; i++) begin
            alu_t[i] = 0; p1_t[i] = 0; p2_t[i] = 0; op2imm_t[i] = 0;
            w_t[i] = 0; m_t[i] = 0; ill_t[i] = 0;
        end
        op2imm_t[1] = 1;                                  // ADD
        alu_t[5] = 1; op2imm_t[5] = 1;                    // AND
        alu_t[9] = 2;                                     // NOT
        p1_t[0] = 1; p2_t[0] = 1;                         // BR
        p1_t[12] = 3;                                     // JMP
        p1_t[2] = 1; p2_t[2] = 1; w_t[2] = 1;             // LD
        p1_t[6] = 2; w_t[6] = 1;                          // LDR
        p1_t[10] = 1; p2_t[10] = 1; w_t[10] = 1; m_t[10] = 1; // LDI
        p1_t[14] = 1; p2_t[14] = 1; w_t[14] = 2;          // LEA
        p1_t[3] = 1; p2_t[3] = 1;                         // ST
        p1_t[7] = 2;                                      // STR
        p1_t[11] = 1; p2_t[11] = 1; m_t[11] = 1;          // STI
`ifdef DECODE_ILLEGAL_TRAP_EN
        ill_t[8] = 1; ill_t[13] = 1; ill_t[15] = 1;
`endif
    endtask

    // Apply inputs, let one rising edge sample them, then record the expected outputs.
    task automatic drive(input logic rst_v, input logic en, input logic [15:0] instr,
                         input logic [15:0] npc);
        int op;
        int e_val;
        reset                = rst_v;
        dec_if.enable_decode = en;
        dec_if.Instr_dout    = instr;
        dec_if.npc_in        = npc;
        @(posedge clock);
        if (!rst_v) begin
            model = '0;
        end else if (en) begin
            op        = int'(instr[15:12]);
            e_val     = alu_t[op] * 16 + p1_t[op] * 4 + p2_t[op] * 2
                      + ((op2imm_t[op] != 0 && instr[5] == 1'b0) ? 1 : 0);
            model.ir  = instr;
            model.npc = npc;
            model.e   = 6'(e_val);
            model.w   = 2'(w_t[op]);
            model.m   = (m_t[op] != 0);
            model.v   = 1'b1;
            model.ill = (ill_t[op] != 0);
        end else begin
            model.v = 1'b0;
        end
        sb.push_back(model);
        #1;
    endtask

    // Monitor: every falling edge compares the DUT outputs with the oldest expectation.
    initial begin
        exp_t x;
        forever begin
            @(negedge clock);
            if (sb.size() > 0) begin
                x = sb.pop_front();
                check("decode_valid", 16'(dec_if.decode_valid), 16'(x.v));
                check("IR", dec_if.IR, x.ir);
                check("npc_out", dec_if.npc_out, x.npc);
                check("E_Control", 16'(dec_if.E_Control), 16'(x.e));
                check("W_Control", 16'(dec_if.W_Control), 16'(x.w));
                check("Mem_Control", 16'(dec_if.Mem_Control), 16'(x.m));
`ifdef DECODE_ILLEGAL_TRAP_EN
                check("illegal_op", 16'(dec_if.illegal_op), 16'(x.ill));
`endif
            end
        end
    end

    // Spot checks of the plan's literal constants, independent of the table model.
    task automatic expect_literal(input string name, input logic [5:0] e, input logic [1:0] w,
                                  input logic m);
        @(negedge clock);
        check({name, "_E"}, 16'(dec_if.E_Control), 16'(e));
        check({name, "_W"}, 16'(dec_if.W_Control), 16'(w));
        check({name, "_M"}, 16'(dec_if.Mem_Control), 16'(m));
        @(posedge clock);
        #1;
    endtask

    initial begin
        fill_tables();
        model = '0;
        reset = 1'b0;
        dec_if.enable_decode = 1'b0;
        dec_if.Instr_dout    = '0;
        dec_if.npc_in        = '0;
        #2;

        drive(1'b0, 1'b1, 16'h1283, 16'h3001);
        drive(1'b0, 1'b1, 16'h1283, 16'h3001);
        drive(1'b1, 1'b1, 16'h1283, 16'h3001);
        drive(1'b1, 1'b1, 16'h52A5, 16'h3002);
        drive(1'b1, 1'b1, 16'hA405, 16'h3003);
        drive(1'b1, 1'b1, 16'hE3FF, 16'h3004);
        drive(1'b1, 1'b1, 16'h1283, 16'h3005);
        drive(1'b1, 1'b0, 16'h5FFF, 16'h4000);
        drive(1'b1, 1'b0, 16'h5FFF, 16'h4001);
        drive(1'b1, 1'b1, 16'hA405, 16'h3006);
        drive(1'b1, 1'b0, 16'hA405, 16'h3006);
        drive(1'b1, 1'b1, 16'h1283, 16'h3007);
        expect_literal("ADD", 6'b000001, 2'b00, 1'b0);
        drive(1'b1, 1'b1, 16'h52A5, 16'h3008);
        expect_literal("AND", 6'b010000, 2'b00, 1'b0);
        drive(1'b1, 1'b1, 16'hA405, 16'h3009);
        expect_literal("LDI", 6'b000110, 2'b01, 1'b1);
        drive(1'b1, 1'b1, 16'hE3FF, 16'h300A);
        expect_literal("LEA", 6'b000110, 2'b10, 1'b0);
        drive(1'b0, 1'b1, 16'h1283, 16'h300B);
        drive(1'b1, 1'b0, 16'h1283, 16'h300B);
        drive(1'b1, 1'b1, 16'h1283, 16'h300C);
        drive(1'b1, 1'b1, 16'hD000, 16'h300D);
        drive(1'b1, 1'b1, 16'h1283, 16'h300E);
        drive(1'b1, 1'b1, 16'hFFFF, 16'hFFFF);
        drive(1'b1, 1'b1, 16'h8000, 16'h0000);

        for (int op = 0; op < 16; op++) begin
            drive(1'b1, 1'b1, 16'(op << 12) | 16'h0020, 16'(op));
            drive(1'b1, 1'b1, 16'(op << 12), 16'(op + 1));
        end

        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(0, 15) != 0), ($urandom_range(0, 3) != 0),
                  16'($urandom), 16'($urandom));
        end

        repeat (4) @(negedge clock);
        total++;
        if (sb.size() != 0)
            $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
        else
            passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
